// File: rtl/lfu_pkg.sv
// Shared types and default sizing for the logic function unit.
package lfu_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } lfu_state_e;

   localparam int N_IN_DEFAULT  = 5;
   localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/lfu_table.sv
// Truth-table storage: serially written bit by bit, read combinationally by argument.
module lfu_table
   import lfu_pkg::*;
#(
   parameter int N_IN = N_IN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_idx_i,
   input  logic            wr_en_i,
   input  logic            wr_bit_i,
   input  logic [N_IN-1:0] rd_addr_i,
   output logic            rd_bit_o,
   output logic            wr_last_o
);

   localparam int DEPTH = 1 << N_IN;

   logic [DEPTH-1:0] tbl_q, tbl_d;
   logic [N_IN-1:0]  idx_q, idx_d;

   // A restart request wins over a write arriving in the same cycle.
   always_comb begin
      tbl_d = tbl_q;
      idx_d = idx_q;
      if (clr_idx_i) begin
         idx_d = '0;
      end else if (wr_en_i) begin
         tbl_d[idx_q] = wr_bit_i;
         idx_d        = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_q <= '0;
         idx_q <= '0;
      end else begin
         tbl_q <= tbl_d;
         idx_q <= idx_d;
      end
   end

   assign rd_bit_o  = tbl_q[rd_addr_i];
   assign wr_last_o = (idx_q == {N_IN{1'b1}});

endmodule

// File: rtl/logic_func_unit.sv
// Programmable N_IN-input boolean function with valid/ready result stream.
// Define LFU_CNT_EN to build the saturating count of delivered ones.
module logic_func_unit
   import lfu_pkg::*;
#(
   parameter int N_IN  = N_IN_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   input  logic             in_valid,
   input  logic [N_IN-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic             out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_ones
);

   lfu_state_e state_q;
   logic       out_valid_q, out_valid_d;
   logic       out_data_q, out_data_d;
   logic       wr_en, wr_last, rd_bit, accept, handshake;

   assign wr_en     = (state_q == LOAD) && cfg_valid && !cfg_start;
   assign handshake = out_valid_q && out_ready;
   assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready) && !cfg_start;
   assign accept    = in_valid && in_ready;

   lfu_table #(.N_IN(N_IN)) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_idx_i (cfg_start),
      .wr_en_i   (wr_en),
      .wr_bit_i  (cfg_bit),
      .rd_addr_i (in_data),
      .rd_bit_o  (rd_bit),
      .wr_last_o (wr_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else if (cfg_start) begin
         state_q <= LOAD;
      end else if (wr_en && wr_last) begin
         state_q <= RUN;
      end
   end

   // A held result keeps its captured value; only a fresh accept replaces it.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_bit;
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign cfg_ready = (state_q == LOAD);
   assign busy      = (state_q == LOAD);

`ifdef LFU_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cfg_start) begin
         cnt_d = '0;
      end else if (handshake && out_data_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_ones = cnt_q;
`else
   assign cnt_ones = '0;
`endif

endmodule

// File: tb/tb_logic_func_unit.sv
// Randomized and directed checks of logic_func_unit (N_IN=5, CNT_W=4) against a truth-table model.
module tb_logic_func_unit;

   localparam int S_EMPTY = 0;
   localparam int S_LOAD  = 1;
   localparam int S_RUN   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [4:0] in_data = '0;
   logic       cfg_ready, in_ready, out_valid, out_data, busy;
   logic [3:0] cnt_ones;
   logic [8:0] obs;

   int         checks = 0;
   int         errors = 0;

   // Model of the specified behaviour: table contents, load position, held result, ones count.
   bit [31:0]  m_tbl;
   int         m_state, m_idx, m_cnt;
   bit         m_ov, m_od;

   logic_func_unit #(.N_IN(5), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .cnt_ones  (cnt_ones)
   );

   always #5 clk = ~clk;

   assign obs = {cfg_ready, busy, in_ready, out_valid, out_data, cnt_ones};

   function automatic logic [3:0] exp_cnt();
`ifdef LFU_CNT_EN
      return 4'(m_cnt);
`else
      return 4'd0;
`endif
   endfunction

   function automatic logic [8:0] exp_vec();
      logic rdy;
      rdy = (m_state == S_RUN) && (!m_ov || out_ready) && !cfg_start;
      return {m_state == S_LOAD, m_state == S_LOAD, rdy, m_ov, m_od, exp_cnt()};
   endfunction

   // Advance the model by one rising edge using the inputs currently driven, then move to the next falling edge.
   task automatic tick();
      bit acc, hs, rd;
      acc = in_valid && (m_state == S_RUN) && (!m_ov || out_ready) && !cfg_start;
      hs  = m_ov && out_ready;
      rd  = m_tbl[in_data];
      if (cfg_start) m_cnt = 0;
      else if (hs && m_od && m_cnt < 15) m_cnt++;
      if (acc) begin
         m_ov = 1'b1;
         m_od = rd;
      end else if (hs) begin
         m_ov = 1'b0;
      end
      if (cfg_start) begin
         m_state = S_LOAD;
         m_idx   = 0;
      end else if (m_state == S_LOAD && cfg_valid) begin
         m_tbl[m_idx] = cfg_bit;
         m_idx++;
         if (m_idx == 32) begin
            m_state = S_RUN;
            m_idx   = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      m_state = S_EMPTY;
      m_idx   = 0;
      m_ov    = 1'b0;
      m_od    = 1'b0;
      m_cnt   = 0;
      m_tbl   = '0;
   endtask

   task automatic load_table(input logic [31:0] v, input bit gaps);
      cfg_start = 1'b1; cfg_valid = 1'b0;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 32; ) begin
         cfg_valid = !gaps || ($urandom_range(0, 3) != 0);
         cfg_bit   = v[i];
         tick();
         if (cfg_valid) i++;
      end
      cfg_valid = 1'b0; cfg_bit = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      do_reset();
      #1;
      checks++;
      if (obs !== 9'd0) begin
         $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'd0); errors++;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         $display("[TB] FAIL reset_release: got %b expected %b", obs, exp_vec()); errors++;
      end
   endtask

   task automatic test_empty();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 5'($urandom_range(0, 31));
         #1;
         checks++;
         if ({in_ready, out_valid} !== 2'b00 || obs !== exp_vec()) begin
            $display("[TB] FAIL empty_no_accept: got %b expected %b", obs, exp_vec()); errors++;
         end
         tick();
      end
      cfg_start = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         $display("[TB] FAIL start_in_empty_ready: got %b expected 0", in_ready); errors++;
      end
      tick();
      tick();
      cfg_start = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || obs !== exp_vec()) begin
         $display("[TB] FAIL start_in_load_no_accept: got %b expected %b", obs, exp_vec()); errors++;
      end
      idle();
   endtask

   task automatic test_back_to_back();
      load_table(32'h0000_0001, 1'b0);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 5'd0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || obs !== exp_vec()) begin
         $display("[TB] FAIL b2b_ready: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      in_data = 5'd5;
      #1;
      checks++;
      if ({out_valid, out_data} !== 2'b11 || obs !== exp_vec()) begin
         $display("[TB] FAIL b2b_first: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data} !== 2'b10 || obs !== exp_vec()) begin
         $display("[TB] FAIL b2b_second: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0 || cnt_ones !== exp_cnt() || obs !== exp_vec()) begin
         $display("[TB] FAIL b2b_count: got %b expected %b", obs, exp_vec()); errors++;
      end
      idle();
   endtask

   task automatic test_backpressure();
      load_table(32'hAAAA_AAAA, 1'b1);
      in_valid = 1'b1; in_data = 5'd3; out_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_data = 5'($urandom_range(0, 31));
         #1;
         checks++;
         if ({out_valid, out_data, in_ready} !== 3'b110 || obs !== exp_vec()) begin
            $display("[TB] FAIL stall_hold: got %b expected %b", obs, exp_vec()); errors++;
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0 || obs !== exp_vec()) begin
         $display("[TB] FAIL stall_single_hs: got %b expected %b", obs, exp_vec()); errors++;
      end
      idle();
   endtask

   task automatic test_reload_pending();
      in_valid = 1'b1; in_data = 5'd3; out_ready = 1'b0;
      tick();
      in_valid = 1'b1; cfg_start = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         $display("[TB] FAIL start_run_ready: got %b expected 0", in_ready); errors++;
      end
      tick();
      in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b1; cfg_bit = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid, out_data} !== 3'b111 || cnt_ones !== 4'd0 || obs !== exp_vec()) begin
         $display("[TB] FAIL pending_after_start: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      tick();
      cfg_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data} !== 2'b11 || obs !== exp_vec()) begin
         $display("[TB] FAIL pending_delivery: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      out_ready = 1'b0;
      load_table(32'h0000_0000, 1'b0);
      in_valid = 1'b1; in_data = 5'd3; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data} !== 2'b10 || obs !== exp_vec()) begin
         $display("[TB] FAIL reload_zero: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      idle();
   endtask

   task automatic test_saturation();
      logic [3:0] sat;
`ifdef LFU_CNT_EN
      sat = 4'd15;
`else
      sat = 4'd0;
`endif
      load_table(32'hFFFF_FFFF, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 5'($urandom_range(0, 31));
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            $display("[TB] FAIL stream_ones: got %b expected %b", obs, exp_vec()); errors++;
         end
         tick();
      end
      in_valid = 1'b0;
      tick();
      #1;
      checks++;
      if (cnt_ones !== sat || obs !== exp_vec()) begin
         $display("[TB] FAIL count_saturate: got %0d expected %0d", cnt_ones, sat); errors++;
      end
      idle();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0; cfg_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cfg_bit = 1'($urandom_range(0, 1));
         tick();
      end
      #2;
      do_reset();
      #1;
      checks++;
      if (obs !== 9'd0) begin
         $display("[TB] FAIL reset_mid_load: got %b expected %b", obs, 9'd0); errors++;
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || obs !== exp_vec()) begin
         $display("[TB] FAIL reload_required: got %b expected %b", obs, exp_vec()); errors++;
      end
      tick();
      idle();
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         load_table($urandom, 1'b1);
         for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_bit   = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== exp_vec()) begin
               $display("[TB] FAIL random_r%0d_c%0d: got %b expected %b", r, i, obs, exp_vec()); errors++;
            end
            tick();
         end
         idle();
         out_ready = 1'b1;
         tick();
         idle();
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_back_to_back();
      test_backpressure();
      test_reload_pending();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_func_unit.md
LOGIC_FUNC_UNIT -- requirements
Module: logic_func_unit

Interface
REQ-001 Parameter N_IN, default 5: width of the function input vector (1..8).
REQ-002 Parameter CNT_W, default 16: width of the ones-result counter.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 cfg_start  input  1: single-cycle pulse that begins a truth-table load.
REQ-006 cfg_valid  input  1: cfg_bit carries a valid table bit this cycle.
REQ-007 cfg_bit  input  1: serial truth-table bit, table index 0 first.
REQ-008 cfg_ready  output  1: table load in progress; bits are accepted.
REQ-009 in_valid  input  1: in_data is valid.
REQ-010 in_data  input  N_IN: function argument; it indexes the truth table.
REQ-011 in_ready  output  1: the block accepts an argument this cycle.
REQ-012 out_valid  output  1: out_data is valid.
REQ-013 out_data  output  1: registered function result.
REQ-014 out_ready  input  1: the downstream block accepts the result.
REQ-015 busy  output  1: high in LOAD state.
REQ-016 cnt_ones  output  CNT_W: count of accepted results equal to 1.

Function
REQ-017 FSM states: EMPTY (no table), LOAD, RUN.
REQ-018 Transitions: EMPTY -> LOAD on cfg_start; LOAD -> RUN on acceptance of the 2^N_IN-th bit; RUN -> LOAD on cfg_start; LOAD + cfg_start -> LOAD with the bit index reset to 0.
REQ-019 Table: 2^N_IN bits; in LOAD, each cfg_valid cycle writes cfg_bit to table[idx] and increments idx. cfg_valid outside LOAD is ignored.
REQ-020 cfg_ready = (state == LOAD).
REQ-021 in_ready = (state == RUN) && (!out_valid || out_ready).
REQ-022 Accept (in_valid && in_ready): on the next edge, out_data = table[in_data] and out_valid = 1. Latency is 1 cycle, with full throughput of 1 result per cycle.
REQ-023 out_valid and out_data are held stable until out_valid && out_ready. Without a new accept in the same cycle, out_valid then clears.
REQ-024 cfg_start in RUN: in_ready drops in that cycle, and no accept occurs in that cycle. A pending result is kept and delivered with its original value; table writes do not alter it.
REQ-025 cfg_start while in_valid is high in EMPTY or LOAD: no accept occurs.
REQ-026 cnt_ones increments on each output handshake where out_data = 1. It saturates at 2^CNT_W-1 and clears to 0 on cfg_start.

Reset
REQ-027 When rst_n is low: state = EMPTY, table = all 0, idx = 0, out_valid = 0, out_data = 0, cnt_ones = 0.
REQ-028 Reset asserted mid-LOAD or mid-handshake aborts immediately. After release the block is in EMPTY, and a full reload is required.

Configuration
REQ-029 Macro LFU_CNT_EN. When defined, the cnt_ones logic of REQ-026 is built. When undefined, the cnt_ones port remains and is tied to 0, and no counter flops are generated.

Structure
REQ-030 Package lfu_pkg holds the FSM state enum and the default constants for N_IN and CNT_W.
REQ-031 Sub-module lfu_table holds the table storage, serial write index and read mux. logic_func_unit holds the FSM, handshake and counter.

Verification (N_IN=5, CNT_W=4)
REQ-032 Load 0x00000001, then in_data = 0 and in_data = 5 back-to-back with out_ready = 1 -> out_data 1 then 0 on consecutive cycles, and cnt_ones = 1.
REQ-033 Load 0xAAAAAAAA, hold out_ready = 0, send in_data = 3 -> out_valid = 1 and out_data = 1 held, in_ready = 0. Raise out_ready -> a single handshake occurs.
REQ-034 Send in_valid in EMPTY -> in_ready = 0 and no out_valid.
REQ-035 Pending result 1 with out_ready = 0, pulse cfg_start -> busy = 1 and cnt_ones = 0. The result is then delivered as 1. Reload 0x00000000 -> in_data = 3 gives 0.
REQ-036 Stream 20 results of 1 -> cnt_ones saturates at 15. Pull rst_n low mid-LOAD at bit 10 -> state = EMPTY and all outputs are 0.
REQ-037 Build without LFU_CNT_EN, rerun REQ-032 -> identical outputs except cnt_ones = 0.
